// File: rtl/coupling_gain_ramp_sequencer.sv
// Crossfades the PAC/harmonic coupling gain pair between modulatory and harmonic regimes
// with a linear, reversible ramp, a request handshake and a post-settle dwell interlock.
module coupling_gain_ramp_sequencer #(
    parameter int WIDTH     = 18,
    parameter int FRAC      = 14,
    parameter int RAMP_LOG2 = 11,
    parameter int MIN_DWELL = 400,
    parameter int GAIN_HI   = 16384,
    parameter int GAIN_LO   = 2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    req_valid,
    input  logic                    req_target,
    output logic                    req_ready,
    input  logic                    force_modulatory,
    output logic signed [WIDTH-1:0] pac_gain,
    output logic signed [WIDTH-1:0] harmonic_gain,
    output logic [1:0]              coupling_mode,
    output logic                    ramp_active,
    output logic                    settle_pulse
);

    localparam int P_W    = RAMP_LOG2 + 1;
    localparam int PROD_W = WIDTH + RAMP_LOG2 + 1;
    localparam int DW_W   = $clog2(MIN_DWELL + 2);

    localparam logic [P_W-1:0]          P_MAX     = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [P_W-1:0]          P_ZERO    = '0;
    localparam logic [DW_W-1:0]         DWELL_SAT = DW_W'(MIN_DWELL);
    localparam logic [PROD_W-1:0]       DELTA     = PROD_W'(GAIN_HI - GAIN_LO);
    localparam logic signed [WIDTH-1:0] G_HI      = WIDTH'(GAIN_HI);
    localparam logic signed [WIDTH-1:0] G_LO      = WIDTH'(GAIN_LO);

    localparam logic [1:0] MODE_MOD  = 2'b00;
    localparam logic [1:0] MODE_RAMP = 2'b01;
    localparam logic [1:0] MODE_HARM = 2'b10;

    // Gains must be ordered, non-negative and representable in the signed Q format.
    if (GAIN_HI <= GAIN_LO || GAIN_LO < 0 || GAIN_HI >= (1 << (WIDTH - 1)) || FRAC >= WIDTH)
    begin : g_param_check
        $error("coupling_gain_ramp_sequencer: invalid gain/format parameters");
    end

    typedef enum logic [1:0] {
        ST_MOD,
        ST_RAMP_UP,
        ST_HARM,
        ST_RAMP_DN
    } state_t;

    state_t                    state;
    logic [P_W-1:0]            p;
    logic [P_W-1:0]            p_next;
    logic [DW_W-1:0]           dwell;
    logic [PROD_W-1:0]         prod;
    logic signed [WIDTH-1:0]   s_next;
    logic                      accept;
    logic                      turn_up;
    logic                      turn_dn;

    // NOTE: req_ready is combinational on force_modulatory so an abort blocks acceptance
    // on the same edge; everything else it depends on is registered.
    assign req_ready = !force_modulatory && (ramp_active || dwell == DWELL_SAT);
    assign accept    = req_valid && req_ready;
    assign turn_up   = accept && req_target;
    assign turn_dn   = force_modulatory || (accept && !req_target);

    // A direction swap holds p for that tick; otherwise ramps step and clamp at the ends.
    always_comb begin
        p_next = p;
        case (state)
            ST_RAMP_UP: if (!turn_dn && p != P_MAX)  p_next = p + 1'b1;
            ST_RAMP_DN: if (!turn_up && p != P_ZERO) p_next = p - 1'b1;
            default:    p_next = p;
        endcase
    end

    always_comb begin
        prod   = DELTA * PROD_W'(p_next);
        s_next = WIDTH'(prod >> RAMP_LOG2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_MOD;
            p             <= '0;
            dwell         <= DWELL_SAT;
            pac_gain      <= G_HI;
            harmonic_gain <= G_LO;
            coupling_mode <= MODE_MOD;
            ramp_active   <= 1'b0;
            settle_pulse  <= 1'b0;
        end else begin
            // NOTE: the settle pulse is one clk wide, so it clears outside the clk_en gate.
            settle_pulse <= 1'b0;
            if (clk_en) begin
                p             <= p_next;
                pac_gain      <= G_HI - s_next;
                harmonic_gain <= G_LO + s_next;
                case (state)
                    ST_MOD: begin
                        if (turn_up) begin
                            state         <= ST_RAMP_UP;
                            coupling_mode <= MODE_RAMP;
                            ramp_active   <= 1'b1;
                        end else if (dwell != DWELL_SAT) begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                    ST_HARM: begin
                        if (turn_dn) begin
                            state         <= ST_RAMP_DN;
                            coupling_mode <= MODE_RAMP;
                            ramp_active   <= 1'b1;
                        end else if (dwell != DWELL_SAT) begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                    ST_RAMP_UP: begin
                        if (turn_dn) begin
                            state <= ST_RAMP_DN;
                        end else if (p_next == P_MAX) begin
                            state         <= ST_HARM;
                            coupling_mode <= MODE_HARM;
                            ramp_active   <= 1'b0;
                            settle_pulse  <= 1'b1;
                            dwell         <= '0;
                        end
                    end
                    ST_RAMP_DN: begin
                        if (turn_up) begin
                            state <= ST_RAMP_UP;
                        end else if (p_next == P_ZERO) begin
                            state         <= ST_MOD;
                            coupling_mode <= MODE_MOD;
                            ramp_active   <= 1'b0;
                            settle_pulse  <= 1'b1;
                            dwell         <= '0;
                        end
                    end
                    default: state <= ST_MOD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coupling_gain_ramp_sequencer.sv
// Scoreboard bench: a position/heading reference model predicts every sample; a monitor
// process pops and compares each prediction on the falling edge.
module tb_coupling_gain_ramp_sequencer;

    localparam int WIDTH     = 18;
    localparam int FRAC      = 14;
    localparam int RAMP_LOG2 = 4;
    localparam int MIN_DWELL = 10;
    localparam int GAIN_HI   = 16384;
    localparam int GAIN_LO   = 2048;
    localparam int RAMP_LEN  = 1 << RAMP_LOG2;
    localparam int STEP      = (GAIN_HI - GAIN_LO) / RAMP_LEN;

    logic clk = 1'b0;
    logic rst, clk_en, req_valid, req_target, force_modulatory;
    logic req_ready, ramp_active, settle_pulse;
    logic signed [WIDTH-1:0] pac_gain, harmonic_gain;
    logic [1:0] coupling_mode;

    coupling_gain_ramp_sequencer #(
        .WIDTH(WIDTH), .FRAC(FRAC), .RAMP_LOG2(RAMP_LOG2),
        .MIN_DWELL(MIN_DWELL), .GAIN_HI(GAIN_HI), .GAIN_LO(GAIN_LO)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_target(req_target), .req_ready(req_ready),
        .force_modulatory(force_modulatory),
        .pac_gain(pac_gain), .harmonic_gain(harmonic_gain),
        .coupling_mode(coupling_mode), .ramp_active(ramp_active),
        .settle_pulse(settle_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int pac;
        int harm;
        int mode;
        bit ramp;
        bit settle;
        bit ready;
        bit in_rst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issued = 0;

    // Reference model: ramp position, direction of travel, dwell ticks.
    int m_pos;
    bit m_moving;
    bit m_heading;
    int m_dwell;
    bit m_settle;
    bit m_accepted;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic bit m_ready(input bit f);
        return !f && (m_moving || m_dwell >= MIN_DWELL);
    endfunction

    task automatic model_reset();
        m_pos      = 0;
        m_moving   = 1'b0;
        m_heading  = 1'b0;
        m_dwell    = MIN_DWELL;
        m_settle   = 1'b0;
        m_accepted = 1'b0;
    endtask

    task automatic model_tick(input bit en, input bit v, input bit t, input bit f);
        bit accept, want_up, want_dn;
        m_settle   = 1'b0;
        m_accepted = 1'b0;
        if (!en) return;
        accept     = v && m_ready(f);
        m_accepted = accept;
        want_up    = accept && t;
        want_dn    = f || (accept && !t);
        if (!m_moving) begin
            if (m_pos == RAMP_LEN ? want_dn : want_up) begin
                m_moving  = 1'b1;
                m_heading = (m_pos == 0);
            end else if (m_dwell < MIN_DWELL) begin
                m_dwell++;
            end
        end else if (m_heading && want_dn) begin
            m_heading = 1'b0;
        end else if (!m_heading && want_up) begin
            m_heading = 1'b1;
        end else begin
            if (m_heading && m_pos < RAMP_LEN) m_pos++;
            else if (!m_heading && m_pos > 0) m_pos--;
            if (m_pos == (m_heading ? RAMP_LEN : 0)) begin
                m_moving = 1'b0;
                m_settle = 1'b1;
                m_dwell  = 0;
            end
        end
    endtask

    // One clk cycle: drive inputs, predict the sample, let the edge happen, advance the model.
    task automatic cycle(input bit r, input bit en, input bit v, input bit t, input bit f);
        exp_t e;
        rst = r; clk_en = en; req_valid = v; req_target = t; force_modulatory = f;
        if (r) model_reset();
        e.idx    = n_issued++;
        e.harm   = GAIN_LO + ((GAIN_HI - GAIN_LO) * m_pos) / RAMP_LEN;
        e.pac    = GAIN_HI + GAIN_LO - e.harm;
        e.mode   = m_moving ? 1 : (m_pos == RAMP_LEN ? 2 : 0);
        e.ramp   = m_moving;
        e.settle = m_settle;
        e.ready  = m_ready(f);
        e.in_rst = r;
        exp_q.push_back(e);
        @(posedge clk);
        if (r) model_reset();
        else   model_tick(en, v, t, f);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic request(input bit t);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b1, 1'b1, t, 1'b0);
            if (m_accepted) break;
        end
        if (!m_accepted) bound_fail("request_accept");
    endtask

    task automatic run_to_pos(input int pos);
        for (int i = 0; i < 100 && m_pos != pos; i++) idle(1);
        if (m_pos != pos) bound_fail("run_to_pos");
    endtask

    task automatic run_to_settle();
        for (int i = 0; i < 100 && m_moving; i++) idle(1);
        if (m_moving) bound_fail("run_to_settle");
        else check("settled_ramp_active", ramp_active, 0);
    endtask

    // Monitor: every falling edge presents one sample to compare.
    int max_step = 0;
    int prev_pac = 0;
    bit have_prev = 1'b0;
    int dut_settles = 0;
    int exp_settles = 0;

    initial begin
        exp_t e;
        int step;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("pac_gain@%0d", e.idx), $signed(pac_gain), e.pac);
                check($sformatf("harmonic_gain@%0d", e.idx), $signed(harmonic_gain), e.harm);
                check($sformatf("gain_sum@%0d", e.idx),
                      $signed(pac_gain) + $signed(harmonic_gain), GAIN_HI + GAIN_LO);
                check($sformatf("coupling_mode@%0d", e.idx), coupling_mode, e.mode);
                check($sformatf("ramp_active@%0d", e.idx), ramp_active, e.ramp);
                check($sformatf("settle_pulse@%0d", e.idx), settle_pulse, e.settle);
                check($sformatf("req_ready@%0d", e.idx), req_ready, e.ready);
                if (settle_pulse === 1'b1) dut_settles++;
                if (e.settle) exp_settles++;
                if (have_prev && !e.in_rst) begin
                    step = int'($signed(pac_gain)) - prev_pac;
                    if (step < 0) step = -step;
                    if (step > max_step) max_step = step;
                end
                prev_pac  = int'($signed(pac_gain));
                have_prev = !e.in_rst;
            end
        end
    end

    initial begin
        rst = 1'b1; clk_en = 1'b0; req_valid = 1'b0; req_target = 1'b0; force_modulatory = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state, with and without clk_en.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Full ramp up with the midpoint crossing, then a dwell-blocked request down.
        request(1'b1);
        run_to_pos(RAMP_LEN / 2);
        check("midpoint_pac", $signed(pac_gain), 9216);
        check("midpoint_harm", $signed(harmonic_gain), 9216);
        run_to_settle();
        request(1'b0);
        run_to_settle();

        // Reversal at p = 5 during a ramp up.
        idle(MIN_DWELL + 1);
        request(1'b1);
        run_to_pos(5);
        request(1'b0);
        run_to_settle();
        check("reversal_end_mode", coupling_mode, 0);

        // Force while dwelling in harmonic, then force against a concurrent harmonic request.
        idle(MIN_DWELL + 1);
        request(1'b1);
        run_to_settle();
        idle(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_to_settle();
        idle(MIN_DWELL + 1);
        request(1'b1);
        run_to_pos(3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_to_settle();

        // Half-rate clk_en, then reset in the middle of the ramp.
        idle(MIN_DWELL + 1);
        request(1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, i[0], 1'b0, 1'b0, 1'b0);
        check("gated_half_ramp_harm", $signed(harmonic_gain), 9216);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("settle_pulse_count", dut_settles, exp_settles);
        check("max_gain_step_ok", max_step <= STEP, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
